instr_fetch: RTL and testbench

- Fetch stage sitting directly downstream of the program counter register.
- Samples the current PC and issues a word read to instruction memory over a req/ready handshake.
- Holds the returned instruction with its PC in a valid/ready output register for decode.
- Emits the one-cycle pcEnable pulse that advances the PC after decode accepts; detects misaligned PC, bus error and memory timeout.

---
 rtl/instr_fetch.sv | 152 +++++++++++++++
 tb/tb_instr_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: samples the PC, reads one word from instruction memory,
// holds it for decode and pulses pcEnable once decode has taken it.
module instr_fetch #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcIn,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    output logic        pcEnable,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    // With TIMEOUT == 0 the counter still needs one bit; it simply wraps unused.
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_HOLD  = 3'd2,
        S_ADV   = 3'd3,
        S_DRAIN = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic        expire;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        expire  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (pcIn[1:0] != 2'b00) begin
                    state_d = S_FAULT;
                    cause_d = CAUSE_MISALIGN;
                end else begin
                    addr_d  = pcIn;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else if (mem_err) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_BUSERR;
                    end else begin
                        ir_d    = mem_rdata;
                        ir_pc_d = addr_q;
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // A flush landing on the expiry cycle has nothing left to drain.
                    if (flush) begin
                        state_d = expire ? S_IDLE : S_DRAIN;
                    end else if (expire) begin
                        state_d = S_FAULT;
                        cause_d = CAUSE_TIMEOUT;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (ir_ready) begin
                    state_d = S_ADV;
                end
            end
            S_ADV: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_ready) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (expire) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FAULT: begin
                if (flush) begin
                    cause_d = CAUSE_NONE;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            ir_q    <= '0;
            ir_pc_q <= '0;
            cnt_q   <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign mem_req     = (state_q == S_REQ);
    assign ir_valid    = (state_q == S_HOLD);
    assign pcEnable    = (state_q == S_ADV);
    assign fault       = (state_q == S_FAULT);
    assign mem_addr    = addr_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: main instance at default TIMEOUT plus TIMEOUT=4 and
// TIMEOUT=0 instances sharing the same stimulus, used only in the timeout scenario.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pcIn;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        ir_ready;

    logic        m_req, m_val, m_pe, m_fault;
    logic [31:0] m_addr, m_ir, m_irpc;
    logic [1:0]  m_cause;
    logic        a_req, a_val, a_pe, a_fault;
    logic [31:0] a_addr, a_ir, a_irpc;
    logic [1:0]  a_cause;
    logic        z_req, z_val, z_pe, z_fault;
    logic [31:0] z_addr, z_ir, z_irpc;
    logic [1:0]  z_cause;

    int n_total;
    int n_bad;

    instr_fetch u_dut (
        .clk(clk), .rst(rst), .pcIn(pcIn), .flush(flush),
        .mem_req(m_req), .mem_addr(m_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .ir_valid(m_val), .ir(m_ir), .ir_pc(m_irpc), .ir_ready(ir_ready),
        .pcEnable(m_pe), .fault(m_fault), .fault_cause(m_cause)
    );

    instr_fetch #(.TIMEOUT(4)) u_to4 (
        .clk(clk), .rst(rst), .pcIn(pcIn), .flush(flush),
        .mem_req(a_req), .mem_addr(a_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .ir_valid(a_val), .ir(a_ir), .ir_pc(a_irpc), .ir_ready(ir_ready),
        .pcEnable(a_pe), .fault(a_fault), .fault_cause(a_cause)
    );

    instr_fetch #(.TIMEOUT(0)) u_to0 (
        .clk(clk), .rst(rst), .pcIn(pcIn), .flush(flush),
        .mem_req(z_req), .mem_addr(z_addr), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .ir_valid(z_val), .ir(z_ir), .ir_pc(z_irpc), .ir_ready(ir_ready),
        .pcEnable(z_pe), .fault(z_fault), .fault_cause(z_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        mem_ready = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = 32'h0;
        ir_ready  = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},   {31'd0, m_req},   32'd0);
        chk({tag, "_val"},   {31'd0, m_val},   32'd0);
        chk({tag, "_pe"},    {31'd0, m_pe},    32'd0);
        chk({tag, "_fault"}, {31'd0, m_fault}, 32'd0);
        chk({tag, "_cause"}, {30'd0, m_cause}, 32'd0);
        chk({tag, "_addr"},  m_addr,           32'd0);
        chk({tag, "_ir"},    m_ir,             32'd0);
        chk({tag, "_irpc"},  m_irpc,           32'd0);
    endtask

    initial begin
        int req_n, val_n, pe_n, ir_bad, addr_bad, aq_n, zq_n;
        n_total = 0;
        n_bad   = 0;
        pcIn    = 32'h0;
        step();

        // Zero-wait fetch at PC 0, decode always ready
        do_reset();
        chk_all_zero("reset");
        ir_ready = 1'b1;
        step();
        chk("t1_req", {31'd0, m_req}, 32'd1);
        chk("t1_addr", m_addr, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h00500093;
        step();
        mem_ready = 1'b0;
        chk("t1_val", {31'd0, m_val}, 32'd1);
        chk("t1_ir", m_ir, 32'h00500093);
        chk("t1_irpc", m_irpc, 32'h0);
        step();
        chk("t1_pe", {31'd0, m_pe}, 32'd1);
        pcIn = 32'h4;
        step();
        chk("t1_pe_off", {31'd0, m_pe}, 32'd0);
        step();
        chk("t1_req2", {31'd0, m_req}, 32'd1);
        chk("t1_addr2", m_addr, 32'h4);

        // Memory waits 3 cycles, decode stalls 5 cycles; pcIn wiggles during REQ
        ir_ready = 1'b0;
        req_n = 0; val_n = 0; pe_n = 0; ir_bad = 0; addr_bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            req_n += int'(m_req);
            val_n += int'(m_val);
            pe_n  += int'(m_pe);
            if (m_val && (m_ir != 32'h00a00113 || m_irpc != 32'h4)) ir_bad++;
            if (m_req && m_addr != 32'h4) addr_bad++;
            mem_ready = (i == 3);
            mem_rdata = (i == 3) ? 32'h00a00113 : 32'h0;
            ir_ready  = (i == 9);
            if (i == 1) pcIn = 32'h100;
            if (i == 4) pcIn = 32'h4;
            if (i == 10) pcIn = 32'h8;
        end
        chk("t2_req_cycles", req_n, 4);
        chk("t2_val_cycles", val_n, 6);
        chk("t2_pe_pulses", pe_n, 1);
        chk("t2_ir_stable", ir_bad, 0);
        chk("t2_addr_stable", addr_bad, 0);

        // Misaligned PC faults without a request; flush clears it
        pcIn = 32'h6;
        do_reset();
        step();
        chk("t3_fault", {31'd0, m_fault}, 32'd1);
        chk("t3_cause", {30'd0, m_cause}, 32'd1);
        req_n = int'(m_req);
        for (int i = 0; i < 4; i++) begin
            step();
            req_n += int'(m_req);
        end
        chk("t3_no_req", req_n, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_fault_clr", {31'd0, m_fault}, 32'd0);
        chk("t3_cause_clr", {30'd0, m_cause}, 32'd0);
        chk("t3_idle_req", {31'd0, m_req}, 32'd0);

        // Bus error on the first REQ cycle
        pcIn = 32'h10;
        do_reset();
        step();
        chk("t4_req", {31'd0, m_req}, 32'd1);
        mem_ready = 1'b1;
        mem_err   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ready = 1'b0;
        mem_err   = 1'b0;
        chk("t4_fault", {31'd0, m_fault}, 32'd1);
        chk("t4_cause", {30'd0, m_cause}, 32'd2);
        val_n = int'(m_val);
        pe_n  = int'(m_pe);
        for (int i = 0; i < 3; i++) begin
            step();
            val_n += int'(m_val);
            pe_n  += int'(m_pe);
        end
        chk("t4_no_val", val_n, 0);
        chk("t4_no_pe", pe_n, 0);
        chk("t4_ir_kept", m_ir, 32'h0);

        // Memory never answers: TIMEOUT=4 faults, TIMEOUT=0 waits indefinitely
        pcIn = 32'h20;
        do_reset();
        aq_n = 0; zq_n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            aq_n += int'(a_req);
            zq_n += int'(z_req);
        end
        chk("t5_to4_req_cycles", aq_n, 4);
        chk("t5_to4_fault", {31'd0, a_fault}, 32'd1);
        chk("t5_to4_cause", {30'd0, a_cause}, 32'd3);
        chk("t5_to0_req_cycles", zq_n, 1000);
        chk("t5_to0_fault", {31'd0, z_fault}, 32'd0);

        // Flush during REQ drains the late response
        pcIn = 32'h30;
        do_reset();
        step();
        chk("t6_req", {31'd0, m_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t6_drain_req", {31'd0, m_req}, 32'd0);
        val_n = int'(m_val);
        step();
        val_n += int'(m_val);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        step();
        mem_ready = 1'b0;
        val_n += int'(m_val);
        chk("t6_no_val", val_n, 0);
        chk("t6_ir_kept", m_ir, 32'h0);
        chk("t6_idle_req", {31'd0, m_req}, 32'd0);
        step();
        chk("t6_refetch", {31'd0, m_req}, 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        mem_ready = 1'b0;
        chk("t6_hold_ir", m_ir, 32'h12345678);
        chk("t6_hold_irpc", m_irpc, 32'h30);
        flush    = 1'b1;
        ir_ready = 1'b1;
        step();
        flush    = 1'b0;
        ir_ready = 1'b0;
        chk("t6_flush_no_pe", {31'd0, m_pe}, 32'd0);
        chk("t6_flush_val", {31'd0, m_val}, 32'd0);
        step();
        chk("t6_req_again", {31'd0, m_req}, 32'd1);
        rst = 1'b0;
        step();
        chk_all_zero("t6_rst_midreq");
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
